// File: rtl/fcpu_reorder_buffer.sv
// Reorder buffer: allocates tags in dispatch order, collects CDB results,
// retires in order, and squashes everything on a mispredicted branch commit.
module fcpu_reorder_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int N_ROB_W    = 4,
  parameter int N_CDB      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  input  logic [2:0]                  dispatch_type,
  input  logic [REG_ADDR_W-1:0]       dispatch_dst_reg,
  output logic [N_ROB_W-1:0]          dispatch_rob_id,
  input  logic [N_CDB-1:0]            cdb_valid,
  input  logic [N_CDB*N_ROB_W-1:0]    cdb_rob_id,
  input  logic [N_CDB*DATA_W-1:0]     cdb_data,
  input  logic [N_CDB-1:0]            cdb_mispredict,
  input  logic [N_ROB_W-1:0]          lookup_rob_id,
  output logic                        lookup_done,
  output logic [DATA_W-1:0]           lookup_data,
  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [2:0]                  commit_type,
  output logic [REG_ADDR_W-1:0]       commit_dst_reg,
  output logic [DATA_W-1:0]           commit_data,
  output logic [N_ROB_W-1:0]          commit_rob_id,
  output logic                        flush
);
  localparam int DEPTH = 2**N_ROB_W;
  localparam logic [2:0] TYPE_BRANCH = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mispredict;
    logic [2:0]            kind;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t [DEPTH-1:0]               rob;
  logic [N_ROB_W-1:0]               head, tail;
  logic [N_ROB_W:0]                 count;
  logic [DEPTH-1:0]                 wb_hit, wb_mp;
  logic [DEPTH-1:0][DATA_W-1:0]     wb_data;
  entry_t                           head_e, look_e;
  logic                             dispatch_fire, commit_fire;

  // Per-entry CDB write select; ascending port scan lets the highest port win.
  always_comb begin
    wb_hit  = '0;
    wb_mp   = '0;
    wb_data = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < N_CDB; p++) begin
        if (cdb_valid[p] && cdb_rob_id[p*N_ROB_W +: N_ROB_W] == N_ROB_W'(e)) begin
          wb_hit[e]  = 1'b1;
          wb_mp[e]   = cdb_mispredict[p];
          wb_data[e] = cdb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign head_e = rob[head];
  assign look_e = rob[lookup_rob_id];

  assign commit_valid   = head_e.valid && head_e.done && !reset;
  assign commit_fire    = commit_valid && commit_ready;
  assign flush          = commit_fire && head_e.kind == TYPE_BRANCH && head_e.mispredict;
  assign commit_type    = head_e.kind;
  assign commit_dst_reg = head_e.dst_reg;
  assign commit_data    = head_e.data;
  assign commit_rob_id  = head;

  // No bypass from commit: a full buffer stays unready even while retiring.
  assign dispatch_ready  = (count < (N_ROB_W+1)'(DEPTH)) && !reset && !flush;
  assign dispatch_fire   = dispatch_valid && dispatch_ready;
  assign dispatch_rob_id = reset ? '0 : tail;

  assign lookup_done = look_e.valid && look_e.done && !reset;
  assign lookup_data = look_e.data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rob   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit[e] && rob[e].valid) begin
          rob[e].done       <= 1'b1;
          rob[e].data       <= wb_data[e];
          rob[e].mispredict <= wb_mp[e];
        end
      end
      if (commit_fire) begin
        rob[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      // The tail slot is never valid when ready, so it cannot collide with a CDB write.
      if (dispatch_fire) begin
        rob[tail].valid      <= 1'b1;
        rob[tail].done       <= 1'b0;
        rob[tail].mispredict <= 1'b0;
        rob[tail].kind       <= dispatch_type;
        rob[tail].dst_reg    <= dispatch_dst_reg;
        tail                 <= tail + 1'b1;
      end
      case ({dispatch_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/fcpu_reorder_buffer.md
FCPU_REORDER_BUFFER -- requirements
Module: fcpu_reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result data width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 SHALL have parameter N_ROB_W, default 4, log2 depth; DEPTH = 2**N_ROB_W entries.
REQ-004 SHALL have parameter N_CDB, default 2, number of common-data-bus write-back ports (>=1).
REQ-005 SHALL run on one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 dispatch_valid  input  1  new instruction offered.
REQ-009 dispatch_ready  output  1  entry available.
REQ-010 dispatch_type  input  3  commit_type_t: 0 integer, 1 float, 2 mem_integer, 3 mem_float, 4 branch.
REQ-011 dispatch_dst_reg  input  REG_ADDR_W  architectural destination.
REQ-012 dispatch_rob_id  output  N_ROB_W  tag allocated to the offered instruction (current tail).
REQ-013 cdb_valid  input  N_CDB  per-port write-back strobe.
REQ-014 cdb_rob_id  input  N_CDB*N_ROB_W  per-port target tag, port i in bits [i*N_ROB_W +: N_ROB_W].
REQ-015 cdb_data  input  N_CDB*DATA_W  per-port result.
REQ-016 cdb_mispredict  input  N_CDB  per-port branch-mispredict flag.
REQ-017 lookup_rob_id  input  N_ROB_W  operand-forwarding query tag.
REQ-018 lookup_done  output  1  queried entry valid and result written.
REQ-019 lookup_data  output  DATA_W  queried entry result.
REQ-020 commit_valid  output  1  head entry ready to retire.
REQ-021 commit_ready  input  1  consumer accepts retirement.
REQ-022 commit_type, commit_dst_reg, commit_data, commit_rob_id  outputs  3 / REG_ADDR_W / DATA_W / N_ROB_W  head entry fields.
REQ-023 flush  output  1  branch-mispredict squash pulse.

Function
REQ-024 Each entry SHALL hold valid, done, mispredict, type, dst_reg, data; head, tail (N_ROB_W bits, wrap modulo DEPTH) and count (N_ROB_W+1 bits) SHALL track occupancy.
REQ-025 dispatch_ready SHALL be 1 iff count < DEPTH, reset low, and flush low; no same-cycle bypass from commit (full + commit in one cycle still gives dispatch_ready=0).
REQ-026 On dispatch_valid && dispatch_ready, entry[tail] SHALL be written valid=1, done=0, mispredict=0, type, dst_reg, and tail SHALL increment, wrapping DEPTH-1 -> 0.
REQ-027 For each port i with cdb_valid[i] and entry[cdb_rob_id_i].valid, the entry SHALL set done=1, data, mispredict=cdb_mispredict[i] at the clock edge; writes to invalid entries SHALL be ignored.
REQ-028 If two ports target the same tag in one cycle, the highest-index port SHALL win.
REQ-029 lookup_done/lookup_data SHALL be combinational from stored state (no CDB bypass); lookup_done=0 for an invalid entry.
REQ-030 commit_valid SHALL equal entry[head].valid && entry[head].done && !reset; commit_* fields SHALL reflect entry[head] combinationally.
REQ-031 On commit_valid && commit_ready, entry[head].valid SHALL clear and head SHALL increment with wrap.
REQ-032 Simultaneous dispatch and commit SHALL leave count unchanged; dispatch-only +1, commit-only -1.
REQ-033 flush SHALL be asserted combinationally in the cycle of a commit handshake whose head entry has type=4 and mispredict=1; in that cycle dispatch_ready SHALL be 0, and CDB writes SHALL be discarded.
REQ-034 At the edge ending a flush cycle, all entries SHALL be invalidated and head=tail=count=0.
REQ-035 A mispredict flag on a non-branch entry SHALL be stored but SHALL NOT cause flush.
REQ-036 Commits SHALL occur strictly in dispatch order, at most one per cycle.

Reset
REQ-037 While reset is high: all entries invalid, head=tail=count=0, dispatch_ready=0, commit_valid=0, flush=0, lookup_done=0, dispatch_rob_id=0; reset SHALL override any concurrent dispatch, CDB write, or commit.
REQ-038 Reset mid-operation SHALL discard all in-flight entries; the first dispatch after reset SHALL receive tag 0.

Verification
REQ-039 Reset, dispatch 3 integer ops to r1,r2,r3 -> tags 0,1,2; CDB writes tag1=0x22, tag0=0x11, tag2=0x33 -> commits in order tag0/0x11/r1, tag1/0x22/r2, tag2/0x33/r3.
REQ-040 Dispatch 16 with no commit -> dispatch_ready=0 at count 16; commit one and dispatch same cycle -> dispatch accepted the following cycle with tag 0 (wrap), count back to 16.
REQ-041 Dispatch branch (tag 0) + 2 ops; CDB tag0 mispredict=1 -> commit of tag0 asserts flush one cycle, next cycle count=0, commit_valid=0, next dispatch gets tag 0.
REQ-042 Both CDB ports write tag 5 same cycle, port0=0xAAAA, port1=0xBBBB -> lookup tag 5 returns done=1, 0xBBBB.
REQ-043 CDB write to tag 7 when entry 7 invalid -> no state change; later dispatch to tag 7 shows lookup_done=0.
REQ-044 Assert reset with 4 entries pending and commit_ready=1 -> no commit occurs, all outputs at reset values, first post-reset dispatch tag 0.
